// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Includes a fairness streak limit, byte-lane steering and misalignment trapping.
module riscv_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, ERR} state_t;

    state_t            state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              d_err_q, d_err_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic [1:0]        ld_size_q, ld_size_d;

    logic        if_v, d_v, d_bad;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, ld_shift;
    logic [3:0]  streak_inc;

    always_comb begin
        // A requester is not re-granted in the cycle its own ack is visible.
        if_v  = if_req & ~if_ack_q;
        d_v   = d_req & ~d_ack_q;
        d_bad = (d_size == 2'b11) || (d_size == 2'b01 && d_addr[0]) ||
                (d_size == 2'b10 && d_addr[1:0] != 2'b00);
        streak_inc = (streak_q == 4'(MAX_D_STREAK)) ? streak_q : streak_q + 4'd1;

        case (d_size)
            2'b00: begin
                be_calc    = 4'b0001 << d_addr[1:0];
                wdata_calc = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = d_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{d_wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = d_wdata;
            end
        endcase

        ld_shift = mem_rdata >> {ld_off_q, 3'b000};
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        ld_off_d    = ld_off_q;
        ld_size_d   = ld_size_q;

        case (state_q)
            IDLE: begin
                if (d_v && d_bad) begin
                    // Error is reported on entry so d_ack follows the sampling edge directly.
                    state_d  = ERR;
                    d_ack_d  = 1'b1;
                    d_err_d  = 1'b1;
                    streak_d = if_v ? streak_inc : 4'd0;
                end else if (d_v && !(if_v && streak_q == 4'(MAX_D_STREAK))) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr & ~ADDR_W'(3);
                    mem_be_d    = be_calc;
                    mem_wdata_d = wdata_calc;
                    ld_off_d    = d_addr[1:0];
                    ld_size_d   = d_size;
                    streak_d    = if_v ? streak_inc : 4'd0;
                end else if (if_v) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr & ~ADDR_W'(3);
                    mem_be_d    = 4'b1111;
                    mem_wdata_d = '0;
                    streak_d    = 4'd0;
                end
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    case (ld_size_q)
                        2'b00:   d_rdata_d = {24'h0, ld_shift[7:0]};
                        2'b01:   d_rdata_d = {16'h0, ld_shift[15:0]};
                        default: d_rdata_d = mem_rdata;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            ld_off_q    <= '0;
            ld_size_q   <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            ld_off_q    <= ld_off_d;
            ld_size_q   <= ld_size_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed and randomized bench for riscv_mem_arbiter against a transaction-level model.
module tb_riscv_mem_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0]  d_size;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack, d_ack, d_err, mem_req, mem_we;
    logic [3:0]  mem_be;

    int n_chk = 0;
    int n_fail = 0;

    // Model: kind 0 idle, 1 fetch in flight, 2 data in flight, 3 error reported.
    int          m_kind, m_streak, m_n, m_off;
    logic        m_req, m_we, m_if_ack, m_d_ack, m_d_err;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    logic [3:0]  m_be;

    riscv_mem_arbiter #(.ADDR_W(32), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_in();
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b00;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    // Advance the model on the current inputs, clock the DUT, compare.
    task automatic step();
        bit was_rst, if_v, d_v;
        logic [31:0] mask;
        was_rst = !rst_n;
        if (was_rst) begin
            m_kind = 0; m_streak = 0; m_req = 0; m_we = 0; m_addr = '0; m_be = '0;
            m_wdata = '0; m_if_ack = 0; m_d_ack = 0; m_d_err = 0;
            m_if_rdata = '0; m_d_rdata = '0;
        end else begin
            if_v = if_req && !m_if_ack;
            d_v  = d_req && !m_d_ack;
            case (m_kind)
                0: begin
                    m_if_ack = 0; m_d_ack = 0; m_d_err = 0;
                    m_n   = 1 << d_size;
                    m_off = int'(d_addr % 4);
                    if (d_v && (d_size == 2'b11 || (m_off % m_n) != 0)) begin
                        m_kind = 3; m_d_ack = 1; m_d_err = 1;
                        m_streak = if_v ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                    end else if (d_v && !(if_v && m_streak == MAXS)) begin
                        m_kind = 2; m_req = 1; m_we = d_we;
                        m_addr = d_addr - 32'(m_off);
                        m_be   = 4'(((1 << m_n) - 1) << m_off);
                        if (m_n == 1)      m_wdata = 32'(d_wdata[7:0]) * 32'h01010101;
                        else if (m_n == 2) m_wdata = 32'(d_wdata[15:0]) * 32'h00010001;
                        else               m_wdata = d_wdata;
                        m_streak = if_v ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                    end else if (if_v) begin
                        m_kind = 1; m_req = 1; m_we = 0; m_be = 4'hf;
                        m_addr = if_addr - (if_addr % 4);
                        m_streak = 0;
                    end
                end
                1, 2: begin
                    if (mem_ack) begin
                        m_req = 0;
                        if (m_kind == 1) begin
                            m_if_ack = 1; m_if_rdata = mem_rdata;
                        end else begin
                            mask = (m_n == 4) ? 32'hffffffff : ((32'd1 << (8 * m_n)) - 32'd1);
                            m_d_ack = 1;
                            m_d_rdata = (mem_rdata >> (8 * m_off)) & mask;
                        end
                        m_kind = 0;
                    end
                end
                default: begin
                    m_d_ack = 0; m_d_err = 0; m_kind = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        chk("mem_req", 32'(mem_req), 32'(m_req));
        chk("if_ack", 32'(if_ack), 32'(m_if_ack));
        chk("d_ack", 32'(d_ack), 32'(m_d_ack));
        chk("d_err", 32'(d_err), 32'(m_d_err));
        if (m_req || was_rst) begin
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_be", 32'(mem_be), 32'(m_be));
        end
        if ((m_req && m_we) || was_rst) chk("mem_wdata", mem_wdata, m_wdata);
        if (m_if_ack || was_rst) chk("if_rdata", if_rdata, m_if_rdata);
        if ((m_d_ack && !m_d_err) || was_rst) chk("d_rdata", d_rdata, m_d_rdata);
    endtask

    initial begin
        logic [31:0] tmp;
        idle_in();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Fetch with zero-latency memory
        if_req = 1; if_addr = 32'h100; mem_ack = 1; mem_rdata = 32'h00000013;
        step();
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_be", 32'(mem_be), 32'hf);
        step();
        chk("t1_ack", 32'(if_ack), 32'd1);
        chk("t1_rdata", if_rdata, 32'h00000013);
        idle_in(); step();

        // Byte store, memory acks three cycles late
        d_req = 1; d_we = 1; d_size = 2'b00; d_addr = 32'h203; d_wdata = 32'hA5;
        step();
        chk("t2_addr", mem_addr, 32'h200);
        chk("t2_be", 32'(mem_be), 32'h8);
        chk("t2_wdata", mem_wdata, 32'hA5A5A5A5);
        step(); step(); step();
        mem_ack = 1; step();
        chk("t2_ack", 32'(d_ack), 32'd1);
        idle_in(); step();

        // Half load, then byte load from the same word
        d_req = 1; d_size = 2'b01; d_addr = 32'h102; mem_ack = 1; mem_rdata = 32'hBEEF1234;
        step();
        chk("t3_be", 32'(mem_be), 32'hc);
        step();
        chk("t3_lh", d_rdata, 32'h0000BEEF);
        d_req = 0; step();
        d_req = 1; d_size = 2'b00; d_addr = 32'h101;
        step(); step();
        chk("t3_lbu", d_rdata, 32'h00000012);
        idle_in(); step();

        // Misaligned word and illegal size
        d_req = 1; d_we = 1; d_size = 2'b10; d_addr = 32'h101; mem_ack = 1;
        step();
        chk("t4_err", 32'(d_err), 32'd1);
        d_req = 0; step();
        d_req = 1; d_size = 2'b11; d_addr = 32'h100;
        step();
        chk("t4_err11", 32'(d_err), 32'd1);
        idle_in(); step();

        // Reset in the middle of a data access; a late ack must be ignored
        d_req = 1; d_size = 2'b10; d_addr = 32'h300;
        step(); step();
        rst_n = 0; step();
        rst_n = 1; idle_in(); mem_ack = 1; step();
        mem_ack = 0; if_req = 1; if_addr = 32'h400; step();
        mem_ack = 1; mem_rdata = 32'h0badf00d; step();
        chk("t6_ack", 32'(if_ack), 32'd1);
        idle_in(); step();

        // Fetch withheld only in data-ack cycles so the streak limit governs the order
        for (int c = 0; c < 600; c++) begin
            d_req = 1; d_we = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
            tmp = $urandom & ~32'h3;
            if (d_size == 2'b00)      tmp = tmp + 32'($urandom_range(0, 3));
            else if (d_size == 2'b01) tmp = tmp + 32'(2 * $urandom_range(0, 1));
            d_addr = tmp; d_wdata = $urandom;
            if_req = !d_ack; if_addr = $urandom;
            mem_ack = 1; mem_rdata = $urandom;
            step();
        end

        // Fully random traffic including occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
            d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
            d_size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            d_addr = $urandom; d_wdata = $urandom;
            mem_ack = ($urandom_range(0, 2) == 0); mem_rdata = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
